mel_frame_sequencer: RTL and testbench
======================================

MEL_FRAME_SEQUENCER -- requirements
Module: mel_frame_sequencer

Interface
REQ-001 SHALL have parameter: MEL_LATENCY, default 2, number of cycles from fb_load to valid fb_feat on the mel filterbank (range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  FFT bin valid.
REQ-005 SHALL have port: in_data  input  16  unsigned FFT magnitude bin.
REQ-006 SHALL have port: in_last  input  1  marks final bin of frame.
REQ-007 SHALL have port: in_ready  output  1  sequencer accepts a bin.
REQ-008 SHALL have port: fb_bins  output  256  packed bins to filterbank; bin k at [16k+15:16k].
REQ-009 SHALL have port: fb_load  output  1  one-cycle start pulse to filterbank.
REQ-010 SHALL have port: fb_feat  input  208  packed filterbank outputs; feature m at [16m+15:16m], m=0..12.
REQ-011 SHALL have port: out_valid  output  1  feature valid.
REQ-012 SHALL have port: out_data  output  16  current mel feature.
REQ-013 SHALL have port: out_index  output  4  feature index 0..12.
REQ-014 SHALL have port: out_last  output  1  high with index 12.
REQ-015 SHALL have port: out_ready  input  1  downstream accepts feature.
REQ-016 SHALL have port: frame_err  output  1  one-cycle pulse on malformed frame.
REQ-017 SHALL have port: frame_cnt  output  8  completed frames, wraps 255->0.

Function
REQ-018 SHALL implement FSM states FILL, LOAD, WAIT, DRAIN; reset state FILL.
REQ-019 FILL: in_ready=1; bin accepted on in_valid&&in_ready; stored at bin index cnt (0..15), cnt increments.
REQ-020 FILL -> LOAD on accepting bin with cnt=15 or with in_last=1, whichever first.
REQ-021 Early in_last (cnt<15): bins cnt+1..15 SHALL be zeroed; frame_err pulses the cycle after acceptance.
REQ-022 16th bin without in_last: frame_err pulses the cycle after acceptance; frame proceeds normally.
REQ-023 In FILL, bin register SHALL be cleared to zero on entry so unfilled bins read 0.
REQ-024 LOAD: fb_load=1 for exactly one cycle T; in_ready=0 in LOAD, WAIT, DRAIN.
REQ-025 fb_bins SHALL be driven directly from the bin register and remain stable from LOAD through end of DRAIN.
REQ-026 WAIT: down-counter SHALL sample fb_feat into a 13-entry feature register at the end of cycle T+MEL_LATENCY, then enter DRAIN.
REQ-027 DRAIN: out_valid=1 from cycle T+MEL_LATENCY+1; out_data=feature[out_index]; out_index starts 0.
REQ-028 out_index SHALL advance only on out_valid&&out_ready; out_data/out_index SHALL hold while out_ready=0.
REQ-029 out_last=1 exactly when out_valid=1 and out_index=12.
REQ-030 Handshake at index 12: out_valid=0 next cycle, frame_cnt increments, state FILL, cnt=0.
REQ-031 fb_feat changes outside the sample edge SHALL not affect out_data.
REQ-032 in_valid during LOAD/WAIT/DRAIN SHALL be ignored (not accepted, no error).
REQ-033 First bin of next frame SHALL be acceptable in the cycle after the final out handshake.

Reset
REQ-034 On rst=1 at a clock edge: state FILL, cnt=0, bin and feature registers 0, out_index=0, frame_cnt=0.
REQ-035 During and after reset: in_ready=1 (after release), fb_load=0, out_valid=0, out_last=0, frame_err=0, out_data=0, fb_bins=0.
REQ-036 Reset mid-frame (any state) SHALL abandon the frame without fb_load, feature output or frame_cnt change.

Verification
REQ-037 Bins 100,200,...,1600 back-to-back, in_last on 16th, MEL_LATENCY=2, out_ready=1 -> fb_load one cycle after 16th accept, fb_bins[15:0]=100, fb_bins[255:240]=1600, 13 features in order, out_last at index 12, frame_cnt=1.
REQ-038 Same frame, out_ready toggling 1/0 each cycle -> each feature held stable while stalled, exactly 13 handshakes, no duplicates or skips.
REQ-039 Four bins 10,20,30,40 with in_last on 4th -> frame_err pulse, fb_bins[63:0] holds them, fb_bins[255:64]=0, normal drain follows.
REQ-040 16 bins, in_last never asserted -> frame_err pulse after 16th accept; 17th bin not accepted until drain completes.
REQ-041 rst asserted during DRAIN at index 5 -> next cycle out_valid=0, frame_cnt unchanged, in_ready=1; subsequent full frame processes correctly.
REQ-042 MEL_LATENCY=5, fb_feat changed at cycle T+3 and T+5 -> features equal value present at end of cycle T+5.

Source files
------------

// File: rtl/mel_frame_sequencer_if.sv
// mel_frame_sequencer_if
// Groups every handshake and bus signal of the mel frame sequencer.
//   Bin input stream   : in_valid, in_data[15:0], in_last, in_ready
//   Filterbank link    : fb_bins[255:0], fb_load, fb_feat[207:0]
//   Feature out stream : out_valid, out_data[15:0], out_index[3:0], out_last, out_ready
//   Status             : frame_err (pulse), frame_cnt[7:0]
// Modport slave is the sequencer side; master is the environment side.
interface mel_frame_sequencer_if;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         in_last;
  logic         in_ready;
  logic [255:0] fb_bins;
  logic         fb_load;
  logic [207:0] fb_feat;
  logic         out_valid;
  logic [15:0]  out_data;
  logic [3:0]   out_index;
  logic         out_last;
  logic         out_ready;
  logic         frame_err;
  logic [7:0]   frame_cnt;

  modport slave (
    input  in_valid, in_data, in_last, fb_feat, out_ready,
    output in_ready, fb_bins, fb_load, out_valid, out_data, out_index,
           out_last, frame_err, frame_cnt
  );

  modport master (
    output in_valid, in_data, in_last, fb_feat, out_ready,
    input  in_ready, fb_bins, fb_load, out_valid, out_data, out_index,
           out_last, frame_err, frame_cnt
  );
endinterface

// File: rtl/mel_frame_sequencer.sv
// mel_frame_sequencer
// Collects up to 16 FFT magnitude bins into a bin register, kicks the mel
// filterbank with a one-cycle fb_load, captures its 13 features after
// MEL_LATENCY cycles and streams them out one per handshake.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mel_frame_sequencer_if.slave (bin input, filterbank link,
//          feature output, frame_err / frame_cnt status)
module mel_frame_sequencer #(
  parameter int unsigned MEL_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mel_frame_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] LAST_BIN  = 4'd15;
  localparam logic [3:0] LAST_FEAT = 4'd12;
  localparam logic [3:0] WAIT_INIT = 4'(MEL_LATENCY - 1);

  state_t       state_r;
  state_t       state_nxt_s;
  logic [3:0]   cnt_r;
  logic [15:0]  bins_r [0:15];
  logic [15:0]  feat_r [0:12];
  logic [3:0]   wait_cnt_r;
  logic [3:0]   out_index_r;
  logic [7:0]   frame_cnt_r;
  logic         frame_err_r;

  logic         accept_s;
  logic         frame_end_s;
  logic         sample_s;
  logic         out_hs_s;
  logic         drain_done_s;

  logic         in_ready_s;
  logic         fb_load_s;
  logic         out_valid_s;
  logic         out_last_s;
  logic [15:0]  out_data_s;

  assign accept_s     = (state_r == FILL) && bus.in_valid;
  assign frame_end_s  = accept_s && ((cnt_r == LAST_BIN) || bus.in_last);
  assign sample_s     = (state_r == WAIT) && (wait_cnt_r == 4'd0);
  assign out_hs_s     = (state_r == DRAIN) && bus.out_ready;
  assign drain_done_s = out_hs_s && (out_index_r == LAST_FEAT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        if (frame_end_s) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = FILL;
        end
      end
      LOAD: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (sample_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = FILL;
      end
    endcase
  end

  // Output decode from the state register
  always_comb begin
    in_ready_s  = 1'b0;
    fb_load_s   = 1'b0;
    out_valid_s = 1'b0;
    out_last_s  = 1'b0;
    out_data_s  = 16'd0;
    case (state_r)
      FILL:    in_ready_s  = 1'b1;
      LOAD:    fb_load_s   = 1'b1;
      WAIT:    out_valid_s = 1'b0;
      DRAIN: begin
        out_valid_s = 1'b1;
        out_last_s  = (out_index_r == LAST_FEAT);
      end
      default: in_ready_s  = 1'b0;
    endcase
    // Index never leaves 0..12; the guard keeps the mux in range.
    if (out_index_r <= LAST_FEAT) begin
      out_data_s = feat_r[out_index_r];
    end else begin
      out_data_s = 16'd0;
    end
  end

  // Bin register and fill counter; cleared when a frame completes so the
  // next frame starts from all-zero bins (unfilled bins of a short frame read 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        bins_r[i] <= 16'd0;
      end
    end else if (drain_done_s) begin
      cnt_r <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        bins_r[i] <= 16'd0;
      end
    end else if (accept_s) begin
      bins_r[cnt_r] <= bus.in_data;
      cnt_r         <= frame_end_s ? 4'd0 : (cnt_r + 4'd1);
    end
  end

  // Malformed-frame pulse: last flag disagrees with bin position 15.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= accept_s && (bus.in_last ^ (cnt_r == LAST_BIN));
    end
  end

  // Latency down-counter; loaded during LOAD so it reaches 0 in cycle T+MEL_LATENCY.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 4'd0;
    end else if (state_r == LOAD) begin
      wait_cnt_r <= WAIT_INIT;
    end else if ((state_r == WAIT) && (wait_cnt_r != 4'd0)) begin
      wait_cnt_r <= wait_cnt_r - 4'd1;
    end
  end

  // Feature register: fb_feat is captured on the single sample edge only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < 13; m++) begin
        feat_r[m] <= 16'd0;
      end
    end else if (sample_s) begin
      for (int m = 0; m < 13; m++) begin
        feat_r[m] <= bus.fb_feat[16*m +: 16];
      end
    end
  end

  // Output index and completed-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_index_r <= 4'd0;
      frame_cnt_r <= 8'd0;
    end else if (drain_done_s) begin
      out_index_r <= 4'd0;
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else if (out_hs_s) begin
      out_index_r <= out_index_r + 4'd1;
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_fb_bins
    assign bus.fb_bins[16*k +: 16] = bins_r[k];
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.fb_load   = fb_load_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_s;
  assign bus.out_index = out_index_r;
  assign bus.out_last  = out_last_s;
  assign bus.frame_err = frame_err_r;
  assign bus.frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_mel_frame_sequencer.sv
// tb_mel_frame_sequencer
// Directed bench: instance A (MEL_LATENCY=2) covers reset, full frames,
// stalls, short/long frames and mid-drain reset; instance B (MEL_LATENCY=5)
// covers the filterbank sample instant. Only the selected instance sees
// in_valid, so the other stays idle in FILL.
module tb_mel_frame_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel_b = 1'b0;
  logic         in_valid = 1'b0;
  logic [15:0]  in_data = 16'd0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b1;
  logic [207:0] fb_feat = 208'd0;

  int n_checks = 0;
  int n_fail   = 0;

  mel_frame_sequencer_if ifa ();
  mel_frame_sequencer_if ifb ();

  assign ifa.in_valid  = in_valid & ~sel_b;
  assign ifb.in_valid  = in_valid & sel_b;
  assign ifa.in_data   = in_data;
  assign ifb.in_data   = in_data;
  assign ifa.in_last   = in_last;
  assign ifb.in_last   = in_last;
  assign ifa.out_ready = out_ready;
  assign ifb.out_ready = out_ready;
  assign ifa.fb_feat   = fb_feat;
  assign ifb.fb_feat   = fb_feat;

  mel_frame_sequencer #(.MEL_LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mel_frame_sequencer #(.MEL_LATENCY(5)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  wire          in_ready_o  = sel_b ? ifb.in_ready  : ifa.in_ready;
  wire [255:0]  fb_bins_o   = sel_b ? ifb.fb_bins   : ifa.fb_bins;
  wire          fb_load_o   = sel_b ? ifb.fb_load   : ifa.fb_load;
  wire          out_valid_o = sel_b ? ifb.out_valid : ifa.out_valid;
  wire [15:0]   out_data_o  = sel_b ? ifb.out_data  : ifa.out_data;
  wire [3:0]    out_index_o = sel_b ? ifb.out_index : ifa.out_index;
  wire          out_last_o  = sel_b ? ifb.out_last  : ifa.out_last;
  wire          frame_err_o = sel_b ? ifb.frame_err : ifa.frame_err;
  wire [7:0]    frame_cnt_o = sel_b ? ifb.frame_cnt : ifa.frame_cnt;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_feat(input logic [15:0] base);
    for (int m = 0; m < 13; m++) begin
      fb_feat[16*m +: 16] = base + 16'(m);
    end
  endtask

  // Feeds n bins of value stepv*(k+1); returns in cycle T (after last accept).
  task automatic feed(input int n, input bit last_on_final, input int stepv);
    for (int k = 0; k < n; k++) begin
      chk("feed_in_ready", in_ready_o, 1'b1);
      in_valid = 1'b1;
      in_data  = 16'(stepv * (k + 1));
      in_last  = last_on_final && (k == n - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // From cycle T, counts cycles until out_valid rises.
  task automatic wait_valid(input int exp_cycles);
    int c = 0;
    while (!out_valid_o && c < 40) begin
      step();
      c++;
    end
    chk("valid_latency", c, exp_cycles);
  endtask

  task automatic drain(input logic [15:0] base, input bit toggle);
    int e = 0;
    int hs = 0;
    bit rdy = 1'b1;
    for (int c = 0; c < 60 && e < 13; c++) begin
      chk("drain_valid", out_valid_o, 1'b1);
      chk("drain_index", out_index_o, e);
      chk("drain_data", out_data_o, base + 16'(e));
      chk("drain_last", out_last_o, e == 12);
      out_ready = rdy;
      step();
      if (rdy) begin
        e++;
        hs++;
      end
      if (toggle) rdy = ~rdy;
    end
    chk("drain_handshakes", hs, 13);
    chk("drain_done_valid", out_valid_o, 1'b0);
    out_ready = 1'b1;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    set_feat(16'hA000);
    step();
    step();
    chk("rst_fb_load", fb_load_o, 1'b0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_last", out_last_o, 1'b0);
    chk("rst_frame_err", frame_err_o, 1'b0);
    chk("rst_out_data", out_data_o, 16'd0);
    chk("rst_fb_bins", fb_bins_o, 256'd0);
    chk("rst_frame_cnt", frame_cnt_o, 8'd0);
    chk("rst_b_out_valid", ifb.out_valid, 1'b0);
    rst = 1'b0;
    chk("rst_in_ready", in_ready_o, 1'b1);

    // Reset during DRAIN at index 5 abandons the frame
    feed(16, 1'b1, 100);
    wait_valid(3);
    for (int i = 0; i < 5; i++) step();
    chk("midrst_index5", out_index_o, 4'd5);
    rst = 1'b1;
    step();
    chk("midrst_out_valid", out_valid_o, 1'b0);
    chk("midrst_frame_cnt", frame_cnt_o, 8'd0);
    chk("midrst_in_ready", in_ready_o, 1'b1);
    chk("midrst_out_index", out_index_o, 4'd0);
    chk("midrst_fb_bins", fb_bins_o, 256'd0);
    chk("midrst_out_data", out_data_o, 16'd0);
    rst = 1'b0;
    step();

    // Full frame 100..1600, out_ready held high
    feed(16, 1'b1, 100);
    chk("f1_fb_load", fb_load_o, 1'b1);
    chk("f1_in_ready_load", in_ready_o, 1'b0);
    chk("f1_frame_err", frame_err_o, 1'b0);
    chk("f1_bin0", fb_bins_o[15:0], 16'd100);
    chk("f1_bin15", fb_bins_o[255:240], 16'd1600);
    step();
    chk("f1_fb_load_pulse", fb_load_o, 1'b0);
    chk("f1_bin15_wait", fb_bins_o[255:240], 16'd1600);
    wait_valid(2);
    set_feat(16'hF000);   // change after the sample edge must not show
    drain(16'hA000, 1'b0);
    chk("f1_frame_cnt", frame_cnt_o, 8'd1);
    chk("f1_in_ready_after", in_ready_o, 1'b1);
    set_feat(16'hA000);

    // Same frame with out_ready toggling
    feed(16, 1'b1, 100);
    wait_valid(3);
    drain(16'hA000, 1'b1);
    chk("f2_frame_cnt", frame_cnt_o, 8'd2);

    // Short frame: four bins, in_last on the 4th
    feed(4, 1'b1, 10);
    chk("short_frame_err", frame_err_o, 1'b1);
    chk("short_fb_load", fb_load_o, 1'b1);
    chk("short_bins_low", fb_bins_o[63:0], 64'h0028_001E_0014_000A);
    chk("short_bins_high", fb_bins_o[255:64], 192'd0);
    step();
    chk("short_err_pulse", frame_err_o, 1'b0);
    wait_valid(2);
    drain(16'hA000, 1'b0);
    chk("short_frame_cnt", frame_cnt_o, 8'd3);

    // Long frame: 16 bins without in_last; a 17th bin waits through drain
    feed(16, 1'b0, 7);
    chk("long_frame_err", frame_err_o, 1'b1);
    chk("long_fb_load", fb_load_o, 1'b1);
    chk("long_bin15", fb_bins_o[255:240], 16'd112);
    in_valid = 1'b1;
    in_data  = 16'd999;
    in_last  = 1'b1;
    chk("long_in_ready_load", in_ready_o, 1'b0);
    wait_valid(3);
    chk("long_in_ready_drain", in_ready_o, 1'b0);
    chk("long_no_err_drain", frame_err_o, 1'b0);
    drain(16'hA000, 1'b0);
    chk("long_frame_cnt", frame_cnt_o, 8'd4);
    chk("next_in_ready", in_ready_o, 1'b1);
    chk("next_bins_cleared", fb_bins_o, 256'd0);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("next_fb_load", fb_load_o, 1'b1);
    chk("next_frame_err", frame_err_o, 1'b1);
    chk("next_fb_bins", fb_bins_o, 256'd999);
    wait_valid(3);
    drain(16'hA000, 1'b0);
    chk("next_frame_cnt", frame_cnt_o, 8'd5);

    // MEL_LATENCY=5: features are the fb_feat present at end of T+5
    sel_b = 1'b1;
    set_feat(16'h1000);
    step();
    feed(16, 1'b1, 3);
    chk("b_fb_load", fb_load_o, 1'b1);
    step();
    step();
    step();
    set_feat(16'h2000);   // cycle T+3
    step();
    step();
    chk("b_valid_t5", out_valid_o, 1'b0);
    set_feat(16'h3000);   // cycle T+5
    step();
    chk("b_valid_t6", out_valid_o, 1'b1);
    set_feat(16'h4000);
    drain(16'h3000, 1'b0);
    chk("b_frame_cnt", frame_cnt_o, 8'd1);
    chk("a_frame_cnt_idle", ifa.frame_cnt, 8'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
